keypad_scan_ctrl: RTL and testbench

- Sequencing controller for the 4x4 hex keypad.
- Drives rows one-hot, samples columns through a 2-flop synchroniser, and locks onto a detected key.
- Confirms the press over a debounce window, then waits for a debounced release.
- Pushes each accepted key code into a small output FIFO with valid/ready handshake, for consumption by the display/record logic.

---
 rtl/keypad_scan_ctrl_if.sv | 12 +
 rtl/keypad_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// Key output handshake between the keypad scanner and its consumer.
//   key_valid : FIFO head holds a key (scanner -> consumer)
//   key_hex   : key code at the FIFO head, 0 when empty (scanner -> consumer)
//   key_ready : consumer takes the head when key_valid & key_ready
interface keypad_scan_ctrl_if;
  logic       key_valid;
  logic [3:0] key_hex;
  logic       key_ready;

  modport master (output key_valid, output key_hex, input key_ready);
  modport slave  (input key_valid, input key_hex, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Scanning controller for a 4x4 hex keypad.
// Drives rows one-hot, samples the columns through a 2-flop synchroniser,
// locks onto the first detected key, confirms it over a debounce window,
// waits for a debounced release, and queues each accepted key in a small FIFO.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   col_values    : raw asynchronous column lines, 1 = key closed
//   row_values    : one-hot row drive
//   key_if        : key_valid / key_hex / key_ready handshake (master side)
//   fifo_count    : current FIFO occupancy
//   overflow      : sticky, a confirmed key was dropped on a full FIFO
//   overflow_clr  : clears overflow (a simultaneous new drop wins)
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_BITS = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  col_values,
  output logic [3:0]                  row_values,
  keypad_scan_ctrl_if.master          key_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  input  logic                        overflow_clr
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  localparam logic [SCW-1:0]           SCAN_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DEB_LAST  = DEBOUNCE_BITS'((1 << DEBOUNCE_BITS) - 2);
  localparam logic [CW-1:0]            FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_CONFIRM,
    ST_HELD
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               row_q, row_d;
  logic [1:0]               col_q, col_d;
  logic [SCW-1:0]           scan_cnt_q, scan_cnt_d;
  logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]               sync1_q, col_sync_q;

  logic                     push;
  logic [3:0]               push_code;
  logic [1:0]               first_col;
  logic                     col_bit;

  logic [3:0]               mem_q [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q;
  logic                     overflow_q;
  logic                     fifo_full, fifo_empty, pop, wr_en, ovf_set;

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-numbered closed column wins when several read 1.
  always_comb begin
    first_col = 2'd0;
    if (col_sync_q[0])      first_col = 2'd0;
    else if (col_sync_q[1]) first_col = 2'd1;
    else if (col_sync_q[2]) first_col = 2'd2;
    else if (col_sync_q[3]) first_col = 2'd3;
  end

  assign col_bit   = col_sync_q[col_q];
  assign push_code = key_code({row_q, col_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SCAN;
      row_q      <= '0;
      col_q      <= '0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      sync1_q    <= '0;
      col_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      sync1_q    <= col_values;
      col_sync_q <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    push       = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (col_sync_q == '0) begin
            row_d = row_q + 2'd1;
          end else begin
            col_d     = first_col;
            deb_cnt_d = '0;
            state_d   = ST_CONFIRM;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      ST_CONFIRM: begin
        if (col_bit) begin
          if (deb_cnt_q == DEB_LAST) begin
            push      = 1'b1;
            deb_cnt_d = '0;
            state_d   = ST_HELD;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          state_d    = ST_SCAN;
          row_d      = row_q + 2'd1;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end
      end
      ST_HELD: begin
        if (!col_bit) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = ST_SCAN;
            row_d      = row_q + 2'd1;
            scan_cnt_d = '0;
            deb_cnt_d  = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          deb_cnt_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && key_if.key_ready;
  assign wr_en      = push && (!fifo_full || pop);
  assign ovf_set    = push && fifo_full && !pop;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ovf_set)           overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  assign row_values       = 4'b0001 << row_q;
  assign key_if.key_valid = !fifo_empty;
  assign key_if.key_hex   = fifo_empty ? 4'h0 : mem_q[rd_ptr_q];
  assign fifo_count       = count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: emulates a keypad matrix around
// the DUT and compares every output each cycle against a behavioural model
// built from the scanning/debounce/FIFO rules with ints and a queue.
module tb_keypad_scan_ctrl;
  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int DEPTH  = 4;
  localparam int WINDOW = (1 << DEB) - 1;

  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_values;
  logic [3:0] row_values;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       overflow_clr;

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .DEBOUNCE_BITS(DEB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .col_values  (col_values),
    .row_values  (row_values),
    .key_if      (kif),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Key legend by {row, col}.
  logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model.
  int         m_row, m_mode, m_dwell, m_run, m_col;
  logic [3:0] m_pipe0, m_pipe1;
  logic [3:0] m_q[$];
  bit         m_ovf;
  bit         m_will_push;

  task automatic model_step(input logic rst, input logic [3:0] col,
                            input logic rdy, input logic clr);
    logic [3:0] s;
    bit push, do_pop, was_full, set;
    logic [3:0] code;
    if (rst) begin
      m_row = 0; m_mode = M_SCAN; m_dwell = 0; m_run = 0; m_col = 0;
      m_pipe0 = '0; m_pipe1 = '0; m_q.delete(); m_ovf = 0; m_will_push = 0;
      return;
    end
    s = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = col;
    push = 0;
    code = '0;
    case (m_mode)
      M_SCAN: begin
        if (m_dwell + 1 == SETTLE) begin
          m_dwell = 0;
          if (s == 4'b0) m_row = (m_row + 1) % 4;
          else begin
            for (int i = 3; i >= 0; i--) if (s[i]) m_col = i;
            m_run = 0;
            m_mode = M_CONFIRM;
          end
        end else m_dwell++;
      end
      M_CONFIRM: begin
        if (s[m_col]) begin
          m_run++;
          if (m_run == WINDOW) begin
            push = 1; code = KEYMAP[m_row*4 + m_col];
            m_run = 0; m_mode = M_HELD;
          end
        end else begin
          m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_dwell = 0; m_run = 0;
        end
      end
      default: begin
        if (!s[m_col]) begin
          m_run++;
          if (m_run == WINDOW) begin
            m_mode = M_SCAN; m_row = (m_row + 1) % 4; m_dwell = 0; m_run = 0;
          end
        end else m_run = 0;
      end
    endcase
    was_full = (m_q.size() == DEPTH);
    do_pop = (m_q.size() > 0) && rdy;
    if (do_pop) void'(m_q.pop_front());
    set = 0;
    if (push) begin
      if (was_full && !do_pop) set = 1;
      else m_q.push_back(code);
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_will_push = (m_mode == M_CONFIRM) && m_pipe1[m_col] && (m_run + 1 == WINDOW);
  endtask

  // Stimulus controls.
  logic [15:0] press_mask = '0;
  logic [3:0]  noise = '0;
  logic        rdy_base = 1'b0;
  logic        clr_base = 1'b0;
  logic        rst_base = 1'b0;
  bit          auto_rdy = 0;

  function automatic logic [3:0] keypad_cols(input logic [3:0] rows, input logic [15:0] mask);
    logic [3:0] c;
    c = '0;
    for (int r = 0; r < 4; r++) if (rows[r] === 1'b1) c = c | mask[r*4 +: 4];
    return c;
  endfunction

  task automatic cycle();
    logic [3:0] c;
    logic       r;
    c = keypad_cols(row_values, press_mask) | noise;
    r = auto_rdy ? m_will_push : rdy_base;
    col_values      = c;
    kif.key_ready   = r;
    overflow_clr    = clr_base;
    reset           = rst_base;
    @(posedge clk);
    model_step(rst_base, c, r, clr_base);
    @(negedge clk);
    chk("row",   32'(row_values),    32'(1) << m_row);
    chk("valid", 32'(kif.key_valid), 32'(m_q.size() > 0));
    chk("hex",   32'(kif.key_hex),   (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("count", 32'(fifo_count),    32'(m_q.size()));
    chk("ovf",   32'(overflow),      32'(m_ovf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_until_held(input int r, input int c);
    int  k;
    press_mask = '0;
    press_mask[r*4 + c] = 1'b1;
    k = 0;
    while (m_mode != M_HELD && k < 200) begin cycle(); k++; end
    chk("press_reach", 32'(m_mode == M_HELD), 32'd1);
  endtask

  task automatic release_until_scan();
    int k;
    press_mask = '0;
    k = 0;
    while (m_mode != M_SCAN && k < 200) begin cycle(); k++; end
    chk("release_reach", 32'(m_mode == M_SCAN), 32'd1);
  endtask

  task automatic press_key(input int r, input int c);
    press_until_held(r, c);
    run(3);
    release_until_scan();
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] exp);
    chk(tag, 32'(kif.key_hex), 32'(exp));
    rdy_base = 1'b1;
    cycle();
    rdy_base = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b1; col_values = '0; overflow_clr = 1'b0; kif.key_ready = 1'b0;
    m_row = 0; m_mode = M_SCAN; m_dwell = 0; m_run = 0; m_col = 0;
    m_pipe0 = '0; m_pipe1 = '0; m_ovf = 0; m_will_push = 0;

    rst_base = 1'b1;
    run(2);
    chk("reset_row", 32'(row_values), 32'd1);
    chk("reset_cnt", 32'(fifo_count), 32'd0);
    rst_base = 1'b0;

    // Idle scanning.
    run(40);

    // Single held key 5.
    press_key(1, 1);
    run(20);
    chk("k5_valid", 32'(kif.key_valid), 32'd1);
    chk("k5_cnt",   32'(fifo_count),    32'd1);
    pop_expect("k5_hex", 4'h5);
    chk("k5_empty", 32'(fifo_count), 32'd0);

    // Short bounce on row 3, col 0.
    k = 0;
    while (row_values !== 4'b1000 && k < 50) begin cycle(); k++; end
    chk("reach_row3", 32'(row_values), 32'h8);
    noise = 4'b0001;
    run(4);
    noise = '0;
    run(20);
    chk("bounce_cnt", 32'(fifo_count), 32'd0);

    // Five keys into a 4-deep FIFO.
    press_key(0, 0); press_key(0, 1); press_key(0, 2); press_key(0, 3); press_key(1, 0);
    chk("ovf_cnt",  32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow),   32'd1);
    pop_expect("ovf_pop0", 4'h1);
    pop_expect("ovf_pop1", 4'h2);
    pop_expect("ovf_pop2", 4'h3);
    pop_expect("ovf_pop3", 4'hA);
    chk("ovf_drained", 32'(fifo_count), 32'd0);
    chk("ovf_sticky",  32'(overflow),   32'd1);
    clr_base = 1'b1; cycle(); clr_base = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Push and pop together on a full FIFO.
    press_key(2, 0); press_key(2, 1); press_key(2, 2); press_key(2, 3);
    chk("full_cnt", 32'(fifo_count), 32'd4);
    auto_rdy = 1;
    press_key(3, 0);
    auto_rdy = 0;
    chk("pp_cnt", 32'(fifo_count), 32'd4);
    chk("pp_ovf", 32'(overflow),   32'd0);
    pop_expect("pp_pop0", 4'h8);
    pop_expect("pp_pop1", 4'h9);
    pop_expect("pp_pop2", 4'hC);
    pop_expect("pp_pop3", 4'hE);

    // Reset while HELD with two keys queued.
    press_key(0, 0);
    press_until_held(0, 1);
    chk("rh_cnt_before", 32'(fifo_count), 32'd2);
    rst_base = 1'b1; cycle(); rst_base = 1'b0;
    chk("rh_cnt",   32'(fifo_count),    32'd0);
    chk("rh_valid", 32'(kif.key_valid), 32'd0);
    chk("rh_row",   32'(row_values),    32'd1);
    press_mask = '0;
    run(10);

    // Randomized episodes.
    for (int ep = 0; ep < 150; ep++) begin
      int dur;
      int nk;
      rst_base = ($urandom_range(0, 24) == 0);
      if (rst_base) begin cycle(); rst_base = 1'b0; end
      press_mask = '0;
      nk = $urandom_range(0, 3);
      for (int j = 0; j < nk && j < 2; j++) press_mask[$urandom_range(0, 15)] = 1'b1;
      dur = $urandom_range(1, 40);
      for (int t = 0; t < dur + 20; t++) begin
        if (t == dur) press_mask = '0;
        noise    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        rdy_base = ($urandom_range(0, 2) == 0);
        clr_base = ($urandom_range(0, 11) == 0);
        cycle();
      end
    end
    noise = '0; rdy_base = 1'b0; clr_base = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
